// File: rtl/rom_router_pkg.sv
// Shared types and constants for the ROM download router and its DIP capture helper.
package rom_router_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        TAIL = 2'd2
    } state_e;

    localparam logic [7:0] ROM_IDX = 8'd0;
    localparam logic [7:0] DSW_IDX = 8'd254;

    // 18 bits so that a full 131072-byte image still compares against ROM_BYTES.
    localparam int CNT_W = 18;

endpackage

// File: rtl/dsw_capture.sv
// DIP-switch byte register file fed from the hps_io download stream; shared with sibling arcade cores.
module dsw_capture
    import rom_router_pkg::*;
#(
    parameter logic [7:0] DSW_INDEX = DSW_IDX
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic [7:0]  dsw0,
    output logic [7:0]  dsw1
);

    logic [7:0] dsw0_q;
    logic [7:0] dsw1_q;
    logic       dsw_hit;

    // Only the first two bytes of a DIP download are meaningful.
    assign dsw_hit = ioctl_wr && (ioctl_index == DSW_INDEX) && (ioctl_addr[24:1] == 24'd0);

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            dsw0_q <= 8'h00;
            dsw1_q <= 8'h00;
        end else if (dsw_hit) begin
            if (ioctl_addr[0]) begin
                dsw1_q <= ioctl_dout;
            end else begin
                dsw0_q <= ioctl_dout;
            end
        end
    end

    assign dsw0 = dsw0_q;
    assign dsw1 = dsw1_q;

endmodule

// File: rtl/rom_download_router.sv
// Routes hps_io ROM bytes to the core dn_* port, captures DIP bytes and holds the core in reset
// until a complete image is loaded. Optional checksum gate: define ROM_CHECKSUM_EN.
module rom_download_router
    import rom_router_pkg::*;
#(
    parameter logic [7:0]       ROM_INDEX   = ROM_IDX,
    parameter logic [7:0]       DSW_INDEX   = DSW_IDX,
    parameter logic [CNT_W-1:0] ROM_BYTES   = CNT_W'(73728),
    parameter int unsigned      TAIL_CYCLES = 16
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic [16:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic        dn_wr,
    output logic [7:0]  dsw0,
    output logic [7:0]  dsw1,
    output logic        core_reset_hold,
    output logic        rom_loaded,
    output logic        load_done,
    output logic        err_short,
    output logic        err_over
`ifdef ROM_CHECKSUM_EN
    ,
    input  logic [15:0] expected_sum,
    output logic [15:0] rom_sum
`endif
);

    localparam int TW = $clog2(TAIL_CYCLES + 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TW-1:0]    tail_q;
    logic             dn_wr_q;
    logic [16:0]      dn_addr_q;
    logic [7:0]       dn_data_q;
    logic             hold_q, loaded_q, done_q, err_short_q, err_over_q;
    logic             rom_sel, addr_ok, start_load, accept, image_ok;

    assign rom_sel    = (ioctl_index == ROM_INDEX);
    assign addr_ok    = (ioctl_addr < {7'd0, ROM_BYTES});
    assign start_load = ioctl_download && rom_sel && (state_q != LOAD);
    assign accept     = (state_q == LOAD) && ioctl_wr && rom_sel && addr_ok;
    assign cnt_d      = (accept && (cnt_q != ROM_BYTES)) ? cnt_q + CNT_W'(1) : cnt_q;

`ifdef ROM_CHECKSUM_EN
    logic [15:0] sum_q, sum_d;

    assign sum_d    = accept ? sum_q + 16'(ioctl_dout) : sum_q;
    assign image_ok = (cnt_d == ROM_BYTES) && (sum_d == expected_sum);
    assign rom_sum  = sum_q;

    always_ff @(posedge clk_sys) begin
        if (!reset_n || start_load) begin
            sum_q <= 16'h0000;
        end else if (state_q == LOAD) begin
            sum_q <= sum_d;
        end
    end
`else
    assign image_ok = (cnt_d == ROM_BYTES);
`endif

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            tail_q      <= '0;
            dn_wr_q     <= 1'b0;
            dn_addr_q   <= 17'd0;
            dn_data_q   <= 8'h00;
            hold_q      <= 1'b1;
            loaded_q    <= 1'b0;
            done_q      <= 1'b0;
            err_short_q <= 1'b0;
            err_over_q  <= 1'b0;
        end else begin
            dn_wr_q <= accept;
            done_q  <= 1'b0;
            if (accept) begin
                dn_addr_q <= ioctl_addr[16:0];
                dn_data_q <= ioctl_dout;
            end
            // A new ROM download restarts from scratch, aborting any tail in progress.
            if (start_load) begin
                state_q     <= LOAD;
                cnt_q       <= '0;
                err_short_q <= 1'b0;
                err_over_q  <= 1'b0;
                loaded_q    <= 1'b0;
                hold_q      <= 1'b1;
            end else begin
                case (state_q)
                    LOAD: begin
                        cnt_q <= cnt_d;
                        if (ioctl_wr && rom_sel && !addr_ok) begin
                            err_over_q <= 1'b1;
                        end
                        if (!ioctl_download) begin
                            state_q     <= TAIL;
                            tail_q      <= '0;
                            loaded_q    <= image_ok;
                            err_short_q <= !image_ok;
                        end
                    end
                    TAIL: begin
                        if (tail_q == TW'(TAIL_CYCLES - 1)) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                            hold_q  <= !loaded_q;
                        end else begin
                            tail_q <= tail_q + TW'(1);
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    dsw_capture #(
        .DSW_INDEX (DSW_INDEX)
    ) u_dsw (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .ioctl_index (ioctl_index),
        .ioctl_wr    (ioctl_wr),
        .ioctl_addr  (ioctl_addr),
        .ioctl_dout  (ioctl_dout),
        .dsw0        (dsw0),
        .dsw1        (dsw1)
    );

    assign dn_wr           = dn_wr_q;
    assign dn_addr         = dn_addr_q;
    assign dn_data         = dn_data_q;
    assign core_reset_hold = hold_q;
    assign rom_loaded      = loaded_q;
    assign load_done       = done_q;
    assign err_short       = err_short_q;
    assign err_over        = err_over_q;

endmodule

// File: tb/tb_rom_download_router.sv
// Self-checking bench for rom_download_router: DIP vector table, directed load/abort sequences
// and randomized loads checked against a transaction-level reference model.
`define CHK(nm, a, e) chk(nm, 32'(a), 32'(e))

module tb_rom_download_router;

    localparam int RB   = 73728;
    localparam int TAIL = 16;
`ifdef ROM_CHECKSUM_EN
    localparam bit CS_EN = 1'b1;
`else
    localparam bit CS_EN = 1'b0;
`endif

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = 25'd0;
    logic [7:0]  ioctl_dout = 8'd0;
    logic [16:0] dn_addr;
    logic [7:0]  dn_data, dsw0, dsw1;
    logic        dn_wr, core_reset_hold, rom_loaded, load_done, err_short, err_over;
    logic [15:0] main_exp = 16'h7000;
    logic [15:0] main_sum;

    always #5 clk_sys = ~clk_sys;

    rom_download_router dut (
        .clk_sys         (clk_sys),
        .reset_n         (reset_n),
        .ioctl_download  (ioctl_download),
        .ioctl_index     (ioctl_index),
        .ioctl_wr        (ioctl_wr),
        .ioctl_addr      (ioctl_addr),
        .ioctl_dout      (ioctl_dout),
        .dn_addr         (dn_addr),
        .dn_data         (dn_data),
        .dn_wr           (dn_wr),
        .dsw0            (dsw0),
        .dsw1            (dsw1),
        .core_reset_hold (core_reset_hold),
        .rom_loaded      (rom_loaded),
        .load_done       (load_done),
        .err_short       (err_short),
        .err_over        (err_over)
`ifdef ROM_CHECKSUM_EN
        ,
        .expected_sum    (main_exp),
        .rom_sum         (main_sum)
`endif
    );

`ifdef ROM_CHECKSUM_EN
    logic [16:0] cs_dn_addr;
    logic [7:0]  cs_dn_data, cs_dsw0, cs_dsw1;
    logic        cs_dn_wr, cs_hold, cs_loaded, cs_done, cs_es, cs_eo;
    logic [15:0] cs_exp = 16'h000A;
    logic [15:0] cs_sum;

    rom_download_router #(.ROM_BYTES(18'd4)) dut_cs (
        .clk_sys         (clk_sys),
        .reset_n         (reset_n),
        .ioctl_download  (ioctl_download),
        .ioctl_index     (ioctl_index),
        .ioctl_wr        (ioctl_wr),
        .ioctl_addr      (ioctl_addr),
        .ioctl_dout      (ioctl_dout),
        .dn_addr         (cs_dn_addr),
        .dn_data         (cs_dn_data),
        .dn_wr           (cs_dn_wr),
        .dsw0            (cs_dsw0),
        .dsw1            (cs_dsw1),
        .core_reset_hold (cs_hold),
        .rom_loaded      (cs_loaded),
        .load_done       (cs_done),
        .err_short       (cs_es),
        .err_over        (cs_eo),
        .expected_sum    (cs_exp),
        .rom_sum         (cs_sum)
    );
`endif

    int n_cmp = 0;
    int n_err = 0;
    int n_dn = 0;
    int n_done = 0;

    // Reference model: phase 0 = idle, 1 = loading, 2 = tail countdown.
    int          m_phase, m_tail, m_cnt;
    logic [15:0] m_sum;
    bit          m_loaded, m_es, m_eo;
    logic [7:0]  m_dsw0, m_dsw1;
    bit          e_wr, e_done;
    logic [16:0] e_addr;
    logic [7:0]  e_data;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_tail = 0; m_cnt = 0; m_sum = 16'h0;
        m_loaded = 0; m_es = 0; m_eo = 0;
        m_dsw0 = 8'h00; m_dsw1 = 8'h00;
        e_wr = 0; e_done = 0; e_addr = 17'd0; e_data = 8'h00;
    endtask

    task automatic model_step(input bit d, input logic [7:0] i, input bit w,
                              input logic [24:0] a, input logic [7:0] o);
        e_wr = 0;
        e_done = 0;
        if (w && i == 8'd254 && a[24:1] == 24'd0) begin
            if (a[0]) m_dsw1 = o; else m_dsw0 = o;
        end
        if (m_phase != 1 && d && i == 8'd0) begin
            m_phase = 1; m_cnt = 0; m_sum = 16'h0; m_loaded = 0; m_es = 0; m_eo = 0;
        end else if (m_phase == 1) begin
            if (w && i == 8'd0) begin
                if (int'(a) < RB) begin
                    e_wr = 1; e_addr = a[16:0]; e_data = o;
                    if (m_cnt < RB) m_cnt++;
                    m_sum = m_sum + 16'(o);
                end else begin
                    m_eo = 1;
                end
            end
            if (!d) begin
                m_phase = 2;
                m_tail = TAIL;
                m_loaded = (m_cnt == RB) && (!CS_EN || m_sum == main_exp);
                m_es = !m_loaded;
            end
        end else if (m_phase == 2) begin
            m_tail--;
            if (m_tail == 0) begin
                m_phase = 0;
                e_done = 1;
            end
        end
    endtask

    task automatic check_all();
        `CHK("dn_wr", dn_wr, e_wr);
        if (e_wr) begin
            `CHK("dn_addr", dn_addr, e_addr);
            `CHK("dn_data", dn_data, e_data);
        end
        `CHK("dsw0", dsw0, m_dsw0);
        `CHK("dsw1", dsw1, m_dsw1);
        `CHK("core_reset_hold", core_reset_hold, (m_phase == 0) ? !m_loaded : 1'b1);
        `CHK("rom_loaded", rom_loaded, m_loaded);
        `CHK("load_done", load_done, e_done);
        `CHK("err_short", err_short, m_es);
        `CHK("err_over", err_over, m_eo);
        if (dn_wr) n_dn++;
        if (load_done) n_done++;
    endtask

    task automatic step(input bit d, input logic [7:0] i, input bit w,
                        input logic [24:0] a, input logic [7:0] o);
        ioctl_download = d; ioctl_index = i; ioctl_wr = w; ioctl_addr = a; ioctl_dout = o;
        model_step(d, i, w, a, o);
        @(posedge clk_sys);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 8'd0, 1'b0, 25'd0, 8'd0);
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        ioctl_download = 1'b0; ioctl_index = 8'd0; ioctl_wr = 1'b0;
        ioctl_addr = 25'd0; ioctl_dout = 8'd0;
        model_reset();
        @(posedge clk_sys);
        #1;
        `CHK("rst_dn_wr", dn_wr, 1'b0);
        `CHK("rst_dn_addr", dn_addr, 17'd0);
        `CHK("rst_dn_data", dn_data, 8'h00);
        `CHK("rst_dsw0", dsw0, 8'h00);
        `CHK("rst_dsw1", dsw1, 8'h00);
        `CHK("rst_hold", core_reset_hold, 1'b1);
        `CHK("rst_loaded", rom_loaded, 1'b0);
        `CHK("rst_done", load_done, 1'b0);
        `CHK("rst_err_short", err_short, 1'b0);
        `CHK("rst_err_over", err_over, 1'b0);
        reset_n = 1'b1;
    endtask

    typedef struct {
        bit          d;
        logic [7:0]  i;
        bit          w;
        logic [24:0] a;
        logic [7:0]  o;
        logic [7:0]  x0;
        logic [7:0]  x1;
    } vec_t;

    vec_t tbl[7];
    int   base_dn, base_done;

    initial begin
        tbl[0] = '{1'b1, 8'd254, 1'b0, 25'd0,     8'h00, 8'h00, 8'h00};
        tbl[1] = '{1'b1, 8'd254, 1'b1, 25'd0,     8'hA5, 8'hA5, 8'h00};
        tbl[2] = '{1'b1, 8'd254, 1'b1, 25'd1,     8'h3C, 8'hA5, 8'h3C};
        tbl[3] = '{1'b1, 8'd254, 1'b1, 25'd2,     8'hFF, 8'hA5, 8'h3C};
        tbl[4] = '{1'b1, 8'd254, 1'b1, 25'h10000, 8'h77, 8'hA5, 8'h3C};
        tbl[5] = '{1'b1, 8'd7,   1'b1, 25'd0,     8'h11, 8'hA5, 8'h3C};
        tbl[6] = '{1'b0, 8'd254, 1'b0, 25'd0,     8'h00, 8'hA5, 8'h3C};

        repeat (2) @(posedge clk_sys);
        apply_reset();

        // DIP capture from IDLE via vector table
        base_dn = n_dn;
        for (int k = 0; k < 7; k++) begin
            step(tbl[k].d, tbl[k].i, tbl[k].w, tbl[k].a, tbl[k].o);
            n_cmp++;
            if (dsw0 !== tbl[k].x0) begin
                n_err++;
                $display("FAIL tbl_dsw0[%0d]: got %0h expected %0h", k, dsw0, tbl[k].x0);
            end
            n_cmp++;
            if (dsw1 !== tbl[k].x1) begin
                n_err++;
                $display("FAIL tbl_dsw1[%0d]: got %0h expected %0h", k, dsw1, tbl[k].x1);
            end
        end
        `CHK("tbl_no_dn_wr", n_dn - base_dn, 0);

        // DIP writes during a ROM load
        step(1'b1, 8'd0, 1'b0, 25'd0, 8'd0);
        for (int k = 0; k < 4; k++) step(1'b1, 8'd0, 1'b1, 25'(k), 8'(k + 8'h40));
        step(1'b1, 8'd254, 1'b1, 25'd0, 8'h12);
        step(1'b1, 8'd254, 1'b1, 25'd1, 8'h34);
        step(1'b1, 8'd254, 1'b1, 25'd0, 8'hA5);
        step(1'b1, 8'd254, 1'b1, 25'd1, 8'h3C);
        step(1'b1, 8'd254, 1'b1, 25'd2, 8'hFF);
        `CHK("load_dsw0", dsw0, 8'hA5);
        `CHK("load_dsw1", dsw1, 8'h3C);
        step(1'b0, 8'd0, 1'b0, 25'd0, 8'd0);
        idle(TAIL + 2);

        // Overflow: only 73727 is routed
        base_dn = n_dn;
        step(1'b1, 8'd0, 1'b0, 25'd0, 8'd0);
        step(1'b1, 8'd0, 1'b1, 25'd73727, 8'h5E);
        step(1'b1, 8'd0, 1'b1, 25'd73728, 8'h6F);
        step(1'b1, 8'd0, 1'b1, 25'd100000, 8'h70);
        step(1'b0, 8'd0, 1'b0, 25'd0, 8'd0);
        n_cmp++;
        if ((n_dn - base_dn) !== 1) begin
            n_err++;
            $display("FAIL ovf_dn_count: got %0d expected 1", n_dn - base_dn);
        end
        n_cmp++;
        if (err_over !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_err_over: got %0b expected 1", err_over);
        end
        idle(TAIL + 2);

        // Short load of 1000 bytes
        step(1'b1, 8'd0, 1'b0, 25'd0, 8'd0);
        for (int k = 0; k < 1000; k++) step(1'b1, 8'd0, 1'b1, 25'(k), 8'(k));
        step(1'b0, 8'd0, 1'b0, 25'd0, 8'd0);
        idle(TAIL + 2);
        `CHK("short_err_short", err_short, 1'b1);
        `CHK("short_loaded", rom_loaded, 1'b0);
        `CHK("short_hold", core_reset_hold, 1'b1);

        // Randomized loads with noise on other indices and random tail aborts
        for (int l = 0; l < 14; l++) begin
            int n, gap;
            gap = int'($urandom_range(1, 4));
            for (int k = 0; k < gap; k++)
                step(1'b1, ($urandom_range(0, 1) == 0) ? 8'd5 : 8'd254, 1'($urandom_range(0, 1)),
                     25'($urandom_range(0, 3)), 8'($urandom));
            step(1'b1, 8'd0, 1'b0, 25'd0, 8'd0);
            n = int'($urandom_range(5, 60));
            for (int k = 0; k < n; k++) begin
                logic [24:0] a;
                a = ($urandom_range(0, 7) == 0) ? 25'(RB + $urandom_range(0, 40000))
                                                 : 25'($urandom_range(0, RB - 1));
                step(1'b1, 8'd0, 1'($urandom_range(0, 3) != 0), a, 8'($urandom));
            end
            step(1'b0, 8'd0, 1'b0, 25'd0, 8'd0);
            idle(int'($urandom_range(0, 20)));
        end
        idle(TAIL + 2);

        // New download 5 cycles into TAIL: no load_done, back in LOAD
        step(1'b1, 8'd0, 1'b0, 25'd0, 8'd0);
        for (int k = 0; k < 10; k++) step(1'b1, 8'd0, 1'b1, 25'(k), 8'(k));
        step(1'b0, 8'd0, 1'b0, 25'd0, 8'd0);
        idle(5);
        base_done = n_done;
        base_dn = n_dn;
        step(1'b1, 8'd0, 1'b0, 25'd0, 8'd0);
        idle(0);
        for (int k = 0; k < TAIL + 4; k++) step(1'b1, 8'd0, 1'b0, 25'd0, 8'd0);
        step(1'b1, 8'd0, 1'b1, 25'd123, 8'h9A);
        step(1'b1, 8'd0, 1'b0, 25'd0, 8'd0);
        `CHK("abort_no_done", n_done - base_done, 0);
        `CHK("abort_in_load_dn", n_dn - base_dn, 1);
        `CHK("abort_hold", core_reset_hold, 1'b1);
        step(1'b0, 8'd0, 1'b0, 25'd0, 8'd0);
        idle(TAIL + 2);

        // Reset mid-load at byte 500
        step(1'b1, 8'd0, 1'b0, 25'd0, 8'd0);
        for (int k = 0; k < 500; k++) step(1'b1, 8'd0, 1'b1, 25'(k), 8'(k));
        apply_reset();
        step(1'b0, 8'd0, 1'b0, 25'd0, 8'd0);

        // Full load
        base_dn = n_dn;
        base_done = n_done;
        step(1'b1, 8'd0, 1'b0, 25'd0, 8'd0);
        for (int k = 0; k < RB; k++) step(1'b1, 8'd0, 1'b1, 25'(k), 8'(k));
        step(1'b0, 8'd0, 1'b0, 25'd0, 8'd0);
        idle(TAIL - 1);
        `CHK("full_no_early_done", n_done - base_done, 0);
        idle(3);
        n_cmp++;
        if ((n_dn - base_dn) !== RB) begin
            n_err++;
            $display("FAIL full_dn_count: got %0d expected %0d", n_dn - base_dn, RB);
        end
        n_cmp++;
        if ((n_done - base_done) !== 1) begin
            n_err++;
            $display("FAIL full_done_pulses: got %0d expected 1", n_done - base_done);
        end
        n_cmp++;
        if (rom_loaded !== 1'b1) begin
            n_err++;
            $display("FAIL full_loaded: got %0b expected 1", rom_loaded);
        end
        n_cmp++;
        if (core_reset_hold !== 1'b0) begin
            n_err++;
            $display("FAIL full_hold: got %0b expected 0", core_reset_hold);
        end
        `CHK("full_err_short", err_short, 1'b0);
        `CHK("full_err_over", err_over, 1'b0);

`ifdef ROM_CHECKSUM_EN
        for (int r = 0; r < 2; r++) begin
            cs_exp = (r == 0) ? 16'h000A : 16'h000B;
            step(1'b1, 8'd0, 1'b0, 25'd0, 8'd0);
            for (int k = 0; k < 4; k++) step(1'b1, 8'd0, 1'b1, 25'(k), 8'(k + 1));
            step(1'b0, 8'd0, 1'b0, 25'd0, 8'd0);
            idle(TAIL + 1);
            `CHK("cs_sum", cs_sum, 16'h000A);
            `CHK("cs_loaded", cs_loaded, r == 0);
            `CHK("cs_err_short", cs_es, r == 1);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
